// File: rtl/psum_col_collector_pkg.sv
// Shared defaults and helpers for the psum column collector.
// Optional build macro: PSUM_RELU_EN (clamps negative psums to zero on output).
package psum_col_collector_pkg;

    localparam int PSUM_BW      = 16;
    localparam int COL          = 8;
    localparam int DEPTH        = 64;
    localparam int SLICE_STRIDE = PSUM_BW;

    // Pointer width: index bits plus one wrap bit to tell full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/psum_col_collector_fifo.sv
// Single-column circular FIFO with wrap-bit pointers and sticky overflow.
// Write to a full column is accepted only when the same edge pops it.
module psum_col_fifo
    import psum_col_collector_pkg::*;
#(
    parameter int W     = PSUM_BW,
    parameter int DEPTH = 64
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_wr,
    input  logic         i_rd,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic         o_empty,
    output logic         o_full,
    output logic         o_overflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_ovf;
    logic [W-1:0]  r_mem [DEPTH];

    logic w_wr_en;
    logic w_rd_en;

    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                        (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_wr_en    = i_wr && (!o_full || i_rd);
    assign w_rd_en    = i_rd && !o_empty;
    assign o_dout     = r_mem[r_rd_ptr[AW-1:0]];
    assign o_overflow = r_ovf;

    // Pointer advance and sticky drop flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (i_wr && !w_wr_en) r_ovf <= 1'b1;
        end
    end

    // Storage is left untouched by reset; pointers alone define contents.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/psum_col_collector.sv
// Per-column skew FIFOs below the MAC array, popped as one aligned row.
// Build macro PSUM_RELU_EN zeroes negative slices as the row is registered.
module psum_col_collector
    import psum_col_collector_pkg::*;
#(
    parameter int COL_N = COL,
    parameter int BW    = PSUM_BW,
    parameter int DEP   = DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [COL_N-1:0]    wr,
    input  logic [COL_N*BW-1:0] in,
    input  logic                rd,
    output logic [COL_N*BW-1:0] out,
    output logic                o_valid,
    output logic                o_ready,
    output logic                o_full,
    output logic                out_valid,
    output logic [COL_N-1:0]    overflow
);

    logic [BW-1:0]       w_head [COL_N];
    logic [COL_N-1:0]    w_empty;
    logic [COL_N-1:0]    w_fullv;
    logic                w_pop;
    logic [COL_N*BW-1:0] w_row;
    logic [COL_N*BW-1:0] r_out;
    logic                r_out_valid;

    assign o_valid   = ~|w_empty;
    assign o_ready   = ~|w_fullv;
    assign o_full    = ~o_ready;
    assign w_pop     = rd && o_valid;
    assign out       = r_out;
    assign out_valid = r_out_valid;

    for (genvar g = 0; g < COL_N; g++) begin : g_col
        psum_col_fifo #(
            .W     (BW),
            .DEPTH (DEP)
        ) u_fifo (
            .i_clk      (clk),
            .i_reset    (reset),
            .i_wr       (wr[g]),
            .i_rd       (w_pop),
            .i_din      (in[g*BW +: BW]),
            .o_dout     (w_head[g]),
            .o_empty    (w_empty[g]),
            .o_full     (w_fullv[g]),
            .o_overflow (overflow[g])
        );
    end

    // Assemble the head row, optionally clamping negative psums to zero.
    always_comb begin
        w_row = '0;
        for (int c = 0; c < COL_N; c++) begin
            w_row[c*BW +: BW] = w_head[c];
`ifdef PSUM_RELU_EN
            if (w_head[c][BW-1]) w_row[c*BW +: BW] = '0;
`endif
        end
    end

    // Output row register and one-cycle valid pulse per accepted pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_pop;
            if (w_pop) r_out <= w_row;
        end
    end

endmodule
